// File: rtl/pulse_width_monitor.sv
// Pulse width monitor: synchronises test_in, measures high-pulse widths
// and queues {width, sat} records for a valid/ready consumer.
module pulse_width_monitor #(
  parameter int WIDTH_W     = 16,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   resetb,
  input  logic                   test_in,
  input  logic                   enable,
  input  logic                   clear_ovf,
  input  logic                   rec_ready,
  output logic                   rec_valid,
  output logic [WIDTH_W-1:0]     rec_width,
  output logic                   rec_sat,
  output logic [CNT_W-1:0]       pulse_count,
  output logic                   overflow,
  output logic                   level,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH_W-1:0] WMAX = '1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, WAIT_LOW, ARMED, MEASURE
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  state_e                 state_q, state_d;
  logic [WIDTH_W-1:0]     width_q, width_d;
  logic                   sat_q, sat_d;
  logic [WIDTH_W:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_q, rd_q;
  logic [AW:0]            lvl_q, lvl_d;
  logic [CNT_W-1:0]       pcnt_q;
  logic                   ovf_q;
  logic                   s, push, pop;
  logic                   full, wr_en, drop;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], test_in};
    end
  end

  always_comb begin
    state_d = state_q;
    width_d = width_q;
    sat_d   = sat_q;
    push    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = s ? WAIT_LOW : ARMED;
        WAIT_LOW: if (!s) state_d = ARMED;
        ARMED: begin
          if (s) begin
            state_d = MEASURE;
            width_d = WIDTH_W'(1);
            sat_d   = 1'b0;
          end
        end
        MEASURE: begin
          if (s) begin
            if (width_q == WMAX) sat_d = 1'b1;
            else width_d = width_q + WIDTH_W'(1);
          end else begin
            state_d = ARMED;
            push    = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      width_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      sat_q   <= sat_d;
    end
  end

  // a pop frees a slot in the same cycle, so a full FIFO still accepts
  assign pop   = rec_valid & rec_ready;
  assign full  = (lvl_q == FULL);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign lvl_d = lvl_q + (AW+1)'(wr_en) - (AW+1)'(pop);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      pcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= {width_q, sat_q};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      lvl_q <= lvl_d;
      if (push) pcnt_q <= pcnt_q + CNT_W'(1);
      if (drop) ovf_q <= 1'b1;
      else if (clear_ovf) ovf_q <= 1'b0;
    end
  end

  assign rec_valid   = (lvl_q != '0);
  assign rec_width   = mem_q[rd_q][WIDTH_W:1];
  assign rec_sat     = mem_q[rd_q][0];
  assign pulse_count = pcnt_q;
  assign overflow    = ovf_q;
  assign level       = s;
  assign fifo_level  = lvl_q;

endmodule

// File: tb/tb_pulse_width_monitor.sv
// Bench for pulse_width_monitor: pulse-level reference model feeds a
// scoreboard queue; a negedge monitor pops and compares.
module tb_pulse_width_monitor;
  localparam int WW   = 4;
  localparam int DEP  = 4;
  localparam int SYN  = 2;
  localparam int CW   = 16;
  localparam int WMAX = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          test_in = 1'b0;
  logic          enable = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          rec_ready = 1'b0;
  logic          rec_valid;
  logic [WW-1:0] rec_width;
  logic          rec_sat;
  logic [CW-1:0] pulse_count;
  logic          overflow;
  logic          level;
  logic [2:0]    fifo_level;

  pulse_width_monitor #(
    .WIDTH_W(WW), .DEPTH(DEP), .SYNC_STAGES(SYN), .CNT_W(CW)
  ) dut (
    .clock(clk), .resetb(rst_n), .test_in(test_in),
    .enable(enable), .clear_ovf(clear_ovf),
    .rec_ready(rec_ready), .rec_valid(rec_valid),
    .rec_width(rec_width), .rec_sat(rec_sat),
    .pulse_count(pulse_count), .overflow(overflow),
    .level(level), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] w;
    logic          sat;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   seen = 0;

  // reference state: histories of the sampled input and of enable
  bit   th[32768];
  bit   sh[32768];
  bit   eh[32768];
  int   k = 0;
  int   occ = 0;
  logic [CW-1:0] m_cnt = '0;
  bit   m_ovf = 1'b0;
  bit   m_lvl = 1'b0;
  int   a;
  int   w;
  bit   ok;
  bit   mpush;
  bit   mpop;
  bit   acc;
  bit   dropped;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // A pulse is recorded when s stayed high for a maximal run [a, k-1],
  // and enable was high from the cycle before the run through the end.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; occ = 0; m_cnt = '0; m_ovf = 1'b0; m_lvl = 1'b0;
      exp_q.delete();
    end else begin
      th[k] = test_in;
      eh[k] = enable;
      sh[k] = (k >= SYN) ? th[k-SYN] : 1'b0;
      mpush = 1'b0;
      w = 0;
      if (k >= 1 && !sh[k] && sh[k-1]) begin
        a = k - 1;
        while (a > 0 && sh[a-1]) a--;
        ok = (a >= 1);
        if (ok) for (int j = a - 1; j <= k; j++) if (!eh[j]) ok = 1'b0;
        if (ok) begin
          mpush = 1'b1;
          w = k - a;
        end
      end
      mpop = (occ > 0) && rec_ready;
      acc = mpush && (occ < DEP || mpop);
      dropped = mpush && !acc;
      if (mpush) m_cnt = m_cnt + 1'b1;
      if (acc) exp_q.push_back(rec_t'{
        w: (w > WMAX) ? WW'(WMAX) : WW'(w), sat: (w > WMAX)});
      occ = occ - int'(mpop) + int'(acc);
      if (dropped) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      m_lvl = (k >= SYN - 1) ? th[k-SYN+1] : 1'b0;
      k++;
    end
  end

  always @(negedge clk) begin
    rec_t r;
    chk("rec_valid", int'(rec_valid), int'(occ != 0));
    chk("fifo_level", int'(fifo_level), occ);
    chk("pulse_count", int'(pulse_count), int'(m_cnt));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("level", int'(level), int'(m_lvl));
    if (rst_n && rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        chk("stale_record", 1, 0);
      end else begin
        r = exp_q.pop_front();
        seen++;
        chk("rec_width", int'(rec_width), int'(r.w));
        chk("rec_sat", int'(rec_sat), int'(r.sat));
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(int hi, int gap);
    test_in = 1'b1;
    step(hi);
    test_in = 1'b0;
    step(gap);
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    enable = 1'b1;
    step(4);

    // reset in the middle of a measurement with records queued
    pulse(2, 4); pulse(3, 4); pulse(4, 4);
    test_in = 1'b1;
    step(5);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    test_in = 1'b0;
    step(5);
    rec_ready = 1'b1;
    step(5);

    // basic and partial pulse
    pulse(5, 6);
    enable = 1'b0;
    test_in = 1'b1;
    step(4);
    enable = 1'b1;
    step(7);
    test_in = 1'b0;
    step(4);
    pulse(3, 6);

    // backpressure and overflow, then drain in order
    rec_ready = 1'b0;
    for (int i = 2; i <= 7; i++) pulse(i, 3);
    step(2);
    rec_ready = 1'b1;
    step(10);

    // saturation around the width limit
    pulse(20, 4); pulse(1, 4); pulse(15, 4); pulse(16, 4);

    // full FIFO with a pop and a push on the same edge
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    rec_ready = 1'b0;
    for (int i = 0; i < DEP; i++) pulse(2, 3);
    test_in = 1'b1;
    step(3);
    test_in = 1'b0;
    step(2);
    rec_ready = 1'b1;
    step(1);
    rec_ready = 1'b0;
    step(3);

    // drop coinciding with clear_ovf, then a lone clear
    test_in = 1'b1;
    step(3);
    test_in = 1'b0;
    step(2);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    step(3);
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    rec_ready = 1'b1;
    step(8);

    // enable dropped mid-measurement
    test_in = 1'b1;
    step(6);
    enable = 1'b0;
    step(2);
    test_in = 1'b0;
    enable = 1'b1;
    step(6);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) test_in = ~test_in;
      enable    = ($urandom_range(0, 49) != 0);
      rec_ready = ($urandom_range(0, 2) == 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      step(1);
    end

    test_in = 1'b0;
    clear_ovf = 1'b0;
    rec_ready = 1'b1;
    step(20);
    chk("drain_empty", exp_q.size(), 0);
    chk("records_seen", int'(seen > 10), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_width_monitor.md
Name: pulse_width_monitor

Overview:
- Consumer stage for the single-bit test signal driven by the test program over the `testSignals` bundle.
- Synchronises the signal into the local clock domain and measures the width of each high pulse in clock cycles.
- Queues width records in a small FIFO, drained through a valid/ready handshake by the checker/scoreboard.
- Keeps a completed-pulse count and a sticky overflow flag.

Parameters:
- WIDTH_W, 16, bits of the measured-width field; the width saturates at 2^WIDTH_W-1.
- DEPTH, 4, record FIFO depth; must be a power of 2 and at least 2.
- SYNC_STAGES, 2, number of input synchroniser flops; at least 2.
- CNT_W, 16, bits of the completed-pulse counter; the counter wraps.

Ports:
- clock  in  1  system clock; everything is on the rising edge.
- resetb  in  1  asynchronous active-low reset.
- test_in  in  1  monitored signal; asynchronous to clock.
- enable  in  1  measurement enable.
- clear_ovf  in  1  single-cycle pulse that clears overflow.
- rec_ready  in  1  consumer accepts the head record.
- rec_valid  out  1  head record is valid.
- rec_width  out  WIDTH_W  width of the head record, in cycles.
- rec_sat  out  1  head record's width saturated.
- pulse_count  out  CNT_W  number of completed pulses.
- overflow  out  1  sticky: at least one record was dropped.
- level  out  1  synchronised level, s.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset:
- Asserting resetb, including mid-pulse, immediately clears every state element.
- Reset values: sync chain 0, FSM in IDLE, FIFO empty, rec_valid 0, rec_width 0, rec_sat 0, pulse_count 0, overflow 0, level 0, fifo_level 0.

Synchroniser:
- s is the output of the last of SYNC_STAGES flops.
- A test_in level sampled high on N consecutive edges produces s high for N consecutive cycles.

FSM states: IDLE, WAIT_LOW, ARMED, MEASURE.
- Any state with enable=0: next state is IDLE; an in-progress measurement is discarded (no record, no count).
- IDLE with enable=1: go to ARMED if s=0, or WAIT_LOW if s=1. A partial pulse already in progress is never measured.
- WAIT_LOW: go to ARMED when s=0.
- ARMED: when s=1, go to MEASURE with width counter set to 1 and sat flag set to 0.
- MEASURE while s=1: width counter increments.
  - At 2^WIDTH_W-1 the counter holds and the sat flag sets.
- MEASURE when s=0: go to ARMED. In that same cycle:
  - push {width, sat} into the FIFO;
  - increment pulse_count (wrapping modulo 2^CNT_W).
- Width equals the number of cycles s was high. Minimum width is 1.

Record FIFO:
- Push in cycle t makes the record visible no earlier than t+1; with the FIFO empty, rec_valid=1 at t+1.
- rec_valid = FIFO not empty.
- rec_width and rec_sat show the head record and stay stable while rec_valid=1 and rec_ready=0.
- Pop occurs when rec_valid and rec_ready are both 1. Records leave in push order.
- Simultaneous push and pop:
  - when full: both happen, occupancy stays DEPTH, no overflow;
  - when empty: the push is stored, no pop.
- Push while full without a pop: the record is dropped, overflow sets, pulse_count still increments.
- clear_ovf clears overflow. If a drop occurs in the same cycle, overflow=1 (set wins).
- The FIFO keeps draining while enable=0.
- fifo_level is updated registered, in the same cycle as the push/pop.

Test Plan:
- Reset mid-operation: 3 records queued, pulse in MEASURE, resetb=0 for 2 cycles → all outputs 0; after release with test_in=0 and enable=1 the FSM reaches ARMED; no stale record appears.
- Basic pulse: enable=1, rec_ready=1, test_in high for 5 cycles → exactly one record, rec_width=5, rec_sat=0; pulse_count=1; rec_valid high for 1 cycle.
- Partial pulse: test_in already high when enable rises, stays high 7 more cycles, then a 3-cycle pulse → only one record, rec_width=3, pulse_count=1.
- Backpressure and overflow: DEPTH=4, rec_ready=0, 6 pulses of widths 2,3,4,5,6,7 → fifo_level=4, overflow=1, pulse_count=6; then rec_ready=1 drains 2,3,4,5 in order and rec_valid drops.
- Saturation: WIDTH_W=4, pulse of 20 cycles → rec_width=15, rec_sat=1. A following 1-cycle pulse → rec_width=1, rec_sat=0.
- Simultaneous events:
  - FIFO full with rec_ready=1 and a push in the same cycle → fifo_level stays 4, overflow=0.
  - Later a drop and clear_ovf in the same cycle → overflow=1.
  - enable deasserted mid-MEASURE → no record, pulse_count unchanged.
